// File: rtl/adder_pkg.sv
// adder_pkg: shared FSM encoding and sizing helper for the chunked ripple adder
package adder_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  // One spare bit so the chunk index never wraps inside an operation
  function automatic int cnt_width(input int n);
    return $clog2(n) + 1;
  endfunction

endpackage

// File: rtl/adder_chunk.sv
// adder_chunk: combinational CHUNK-bit ripple of full-adder cells
module adder_chunk #(
  parameter int CHUNK = 4
) (
  input  logic [CHUNK-1:0] a,
  input  logic [CHUNK-1:0] b,
  input  logic             cin,
  output logic [CHUNK-1:0] sum,
  output logic             cout,
  output logic             cmsb
);

  logic [CHUNK:0] c;

  assign c[0] = cin;

  for (genvar i = 0; i < CHUNK; i++) begin : g_fa
    assign sum[i]  = a[i] ^ b[i] ^ c[i];
    assign c[i+1]  = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
  end

  assign cout = c[CHUNK];
  assign cmsb = c[CHUNK-1];

endmodule

// File: rtl/chunked_ripple_adder.sv
// chunked_ripple_adder: multi-cycle adder/subtractor summing CHUNK bits per clock
module chunked_ripple_adder
  import adder_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int CHUNK = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] left,
  input  logic [WIDTH-1:0] right,
  input  logic             carry_in,
  input  logic             subtract,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             carry_out,
  output logic             overflow
);

  localparam int NUM_CHUNKS = WIDTH / CHUNK;
  localparam int KW = cnt_width(NUM_CHUNKS);

  if (WIDTH < 1 || CHUNK < 1 || WIDTH % CHUNK != 0) begin : g_bad_params
    $error("chunked_ripple_adder: CHUNK must divide WIDTH and WIDTH must be >= 1");
  end

  state_t               state;
  logic [WIDTH-1:0]     a_reg;
  logic [WIDTH-1:0]     b_reg;
  logic                 carry_reg;
  logic [KW-1:0]        k;
  logic [CHUNK-1:0]     chunk_sum;
  logic                 chunk_cout;
  logic                 chunk_cmsb;
  logic [WIDTH+CHUNK-1:0] sum_next;

  // Operands shift down one chunk per cycle, so the active chunk is always
  // the low slice; results shift in from the top and land in place after
  // the final chunk.
  adder_chunk #(.CHUNK(CHUNK)) u_chunk (
    .a    (a_reg[CHUNK-1:0]),
    .b    (b_reg[CHUNK-1:0]),
    .cin  (carry_reg),
    .sum  (chunk_sum),
    .cout (chunk_cout),
    .cmsb (chunk_cmsb)
  );

  assign sum_next  = {chunk_sum, sum};
  assign in_ready  = (state == IDLE) && !reset;
  assign out_valid = (state == DONE);

  // Handshake FSM, operand/carry shifting and result latching
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      sum       <= '0;
      carry_out <= 1'b0;
      overflow  <= 1'b0;
      carry_reg <= 1'b0;
      k         <= '0;
    end else begin
      case (state)
        IDLE: if (in_valid) begin
          a_reg     <= left;
          b_reg     <= subtract ? ~right : right;
          carry_reg <= carry_in;
          k         <= '0;
          state     <= BUSY;
        end
        BUSY: begin
          sum       <= sum_next[WIDTH+CHUNK-1:CHUNK];
          a_reg     <= a_reg >> CHUNK;
          b_reg     <= b_reg >> CHUNK;
          carry_reg <= chunk_cout;
          k         <= k + 1'b1;
          if (k == KW'(NUM_CHUNKS - 1)) begin
            carry_out <= chunk_cout;
            overflow  <= chunk_cout ^ chunk_cmsb;
            state     <= DONE;
          end
        end
        DONE: if (out_ready) state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_chunked_ripple_adder.sv
// tb_chunked_ripple_adder: directed and randomized checks at CHUNK=4, 1 and 16
module tb_chunked_ripple_adder;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid  [3];
  logic        out_ready [3];
  logic        carry_in  [3];
  logic        subtract  [3];
  logic [15:0] left      [3];
  logic [15:0] right     [3];
  logic [15:0] sum       [3];
  logic        in_ready  [3];
  logic        out_valid [3];
  logic        carry_out [3];
  logic        overflow  [3];
  logic        chk_en = 1'b0;
  int          total = 0;
  int          bad = 0;

  always #5 clk = ~clk;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      if (bad < 30) $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference arithmetic straight from the definition: {ovf, cout, sum}
  function automatic logic [17:0] ref_add(input logic [15:0] a, input logic [15:0] b,
                                          input logic ci, input logic sb);
    logic [15:0] bb;
    logic [16:0] t;
    bb = sb ? ~b : b;
    t  = {1'b0, a} + {1'b0, bb} + {16'b0, ci};
    return {(a[15] == bb[15]) && (t[15] != a[15]), t[16], t[15:0]};
  endfunction

  for (genvar g = 0; g < 3; g++) begin : g_inst
    localparam int CH = (g == 0) ? 4 : (g == 1) ? 1 : 16;
    localparam int N  = 16 / CH;

    chunked_ripple_adder #(.WIDTH(16), .CHUNK(CH)) dut (
      .clk       (clk),
      .reset     (reset),
      .in_valid  (in_valid[g]),
      .in_ready  (in_ready[g]),
      .left      (left[g]),
      .right     (right[g]),
      .carry_in  (carry_in[g]),
      .subtract  (subtract[g]),
      .out_valid (out_valid[g]),
      .out_ready (out_ready[g]),
      .sum       (sum[g]),
      .carry_out (carry_out[g]),
      .overflow  (overflow[g])
    );

    int          e = 0;
    int          due = 0;
    bit          pend = 1'b0;
    logic [17:0] exp_res = '0;

    // Timeline model: an accepted op becomes visible N edges later and
    // stays until consumed; reset drops whatever is pending.
    always @(posedge clk) begin
      e <= e + 1;
      if (reset) pend <= 1'b0;
      else if (!pend && in_valid[g]) begin
        pend    <= 1'b1;
        due     <= e + 1 + N;
        exp_res <= ref_add(left[g], right[g], carry_in[g], subtract[g]);
      end else if (pend && e >= due && out_ready[g]) pend <= 1'b0;
    end

    always @(negedge clk) begin
      #2;
      if (chk_en) begin
        check($sformatf("in_ready%0d", CH), {31'b0, in_ready[g]}, {31'b0, !pend && !reset});
        check($sformatf("out_valid%0d", CH), {31'b0, out_valid[g]}, {31'b0, pend && e >= due});
        if (pend && e >= due) begin
          check($sformatf("sum%0d", CH), {16'b0, sum[g]}, {16'b0, exp_res[15:0]});
          check($sformatf("cout%0d", CH), {31'b0, carry_out[g]}, {31'b0, exp_res[16]});
          check($sformatf("ovf%0d", CH), {31'b0, overflow[g]}, {31'b0, exp_res[17]});
        end
      end
    end
  end

  // Directed op on the CHUNK=4 instance; optionally stalls in DONE for hold cycles
  task automatic op(input string nm, input logic [15:0] a, input logic [15:0] b,
                    input logic ci, input logic sb, input logic [15:0] xs,
                    input logic xc, input logic xo, input int hold);
    int lat;
    check({nm, "_ready"}, {31'b0, in_ready[0]}, 32'd1);
    left[0] = a; right[0] = b; carry_in[0] = ci; subtract[0] = sb;
    in_valid[0] = 1'b1; out_ready[0] = 1'b0;
    @(negedge clk);
    in_valid[0] = 1'b0;
    lat = 0;
    while (!out_valid[0] && lat < 50) begin
      @(negedge clk);
      lat++;
    end
    check({nm, "_latency"}, lat, 32'd4);
    check({nm, "_sum"}, {16'b0, sum[0]}, {16'b0, xs});
    check({nm, "_cout"}, {31'b0, carry_out[0]}, {31'b0, xc});
    check({nm, "_ovf"}, {31'b0, overflow[0]}, {31'b0, xo});
    for (int i = 0; i < hold; i++) begin
      in_valid[0] = 1'b1;
      left[0] = 16'($urandom); right[0] = 16'($urandom);
      @(negedge clk);
      check({nm, "_hold_sum"}, {16'b0, sum[0]}, {16'b0, xs});
      check({nm, "_hold_valid"}, {31'b0, out_valid[0]}, 32'd1);
      check({nm, "_hold_ready"}, {31'b0, in_ready[0]}, 32'd0);
    end
    in_valid[0] = 1'b0;
    out_ready[0] = 1'b1;
    @(negedge clk);
    out_ready[0] = 1'b0;
    check({nm, "_idle_ready"}, {31'b0, in_ready[0]}, 32'd1);
    check({nm, "_idle_valid"}, {31'b0, out_valid[0]}, 32'd0);
  endtask

  // Fully random per-cycle stimulus with a bias toward carry-heavy operands
  task automatic rnd(input int idx, input int cycles);
    logic [15:0] corners [4];
    corners[0] = 16'hFFFF; corners[1] = 16'h0000; corners[2] = 16'h8000; corners[3] = 16'h7FFF;
    for (int i = 0; i < cycles; i++) begin
      @(negedge clk);
      in_valid[idx]  = ($urandom_range(0, 9) < 7);
      out_ready[idx] = ($urandom_range(0, 9) < 7);
      carry_in[idx]  = 1'($urandom);
      subtract[idx]  = 1'($urandom);
      left[idx]  = ($urandom_range(0, 3) == 0) ? corners[$urandom_range(0, 3)] : 16'($urandom);
      right[idx] = ($urandom_range(0, 3) == 0) ? corners[$urandom_range(0, 3)] : 16'($urandom);
    end
    @(negedge clk);
    in_valid[idx] = 1'b0;
  endtask

  initial begin
    for (int i = 0; i < 3; i++) begin
      in_valid[i] = 1'b0; out_ready[i] = 1'b0; carry_in[i] = 1'b0; subtract[i] = 1'b0;
      left[i] = '0; right[i] = '0;
    end
    reset = 1'b1;
    repeat (2) @(negedge clk);
    chk_en = 1'b1;
    check("rst_ready", {31'b0, in_ready[0]}, 32'd0);
    check("rst_valid", {31'b0, out_valid[0]}, 32'd0);
    check("rst_sum", {16'b0, sum[0]}, 32'd0);
    check("rst_cout", {31'b0, carry_out[0]}, 32'd0);
    check("rst_ovf", {31'b0, overflow[0]}, 32'd0);
    reset = 1'b0;
    @(negedge clk);

    op("basic",    16'h1234, 16'h4321, 1'b0, 1'b0, 16'h5555, 1'b0, 1'b0, 0);
    op("ripple",   16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0, 0);
    op("posovf",   16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1, 0);
    op("negovf",   16'h8000, 16'h8000, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b1, 0);
    op("borrow",   16'h0005, 16'h0007, 1'b1, 1'b1, 16'hFFFE, 1'b0, 1'b0, 0);
    op("noborrow", 16'h0007, 16'h0005, 1'b1, 1'b1, 16'h0002, 1'b1, 1'b0, 0);
    op("stall",    16'hA5A5, 16'h0F0F, 1'b1, 1'b0, 16'hB4B5, 1'b0, 1'b0, 5);

    // Reset lands on the second BUSY edge; the op must vanish
    left[0] = 16'h1111; right[0] = 16'h2222; carry_in[0] = 1'b0; subtract[0] = 1'b0;
    in_valid[0] = 1'b1; out_ready[0] = 1'b1;
    @(negedge clk);
    in_valid[0] = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    check("midrst_ready_hi", {31'b0, in_ready[0]}, 32'd0);
    check("midrst_valid_hi", {31'b0, out_valid[0]}, 32'd0);
    reset = 1'b0;
    @(negedge clk);
    check("midrst_ready", {31'b0, in_ready[0]}, 32'd1);
    for (int i = 0; i < 10; i++) begin
      check("midrst_no_valid", {31'b0, out_valid[0]}, 32'd0);
      @(negedge clk);
    end
    out_ready[0] = 1'b0;

    fork
      rnd(0, 20000);
      rnd(1, 20000);
      rnd(2, 20000);
    join
    repeat (40) begin
      @(negedge clk);
      for (int i = 0; i < 3; i++) out_ready[i] = 1'b1;
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
